// File: rtl/morph_window_ctrl.sv
// -----------------------------------------------------------------------------
// morph_window_ctrl
// Frame sequencer for a 3x3 morphology window fed by line buffers. It accepts
// PIC_WIDTH*PIC_HEIGHT pixels from upstream and then flushes PIC_WIDTH+1 extra
// shifts so that the last pixel reaches the window center. Each shift that
// places a real pixel at the center produces a win_valid pulse with the
// center's raster coordinates and image-edge flags.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle frame start request (honoured in IDLE only)
//   pix_valid  in   upstream pixel available this cycle
//   pix_ready  out  controller accepts a pixel this cycle (RUN only)
//   lb_shift   out  shift enable for line buffers / window registers
//   win_valid  out  window center pixel valid (qualifies border/out_col/out_row)
//   border     out  {top, bottom, left, right} edge flags of the center pixel
//   out_col    out  column of the center pixel
//   out_row    out  row of the center pixel
//   busy       out  high in every state except IDLE
//   frame_done out  single-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module morph_window_ctrl #(
  parameter logic [10:0] PIC_WIDTH  = 11'd250,
  parameter logic [10:0] PIC_HEIGHT = 11'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        lb_shift,
  output logic        win_valid,
  output logic [3:0]  border,
  output logic [10:0] out_col,
  output logic [10:0] out_row,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Frame size and the shift index at which the center holds pixel 0.
  localparam logic [21:0] TOTAL_PIX  = 22'(PIC_WIDTH) * 22'(PIC_HEIGHT);
  localparam logic [21:0] WIN_START  = 22'(PIC_WIDTH) + 22'd1;
  // Pre-increment shift count of the final flush shift.
  localparam logic [21:0] FLUSH_LAST = TOTAL_PIX + 22'(PIC_WIDTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [21:0] r_pix_cnt;
  logic [21:0] r_shift_cnt;
  logic [10:0] r_cen_col;
  logic [10:0] r_cen_row;
  logic        w_accept;
  logic        w_frame_start;
  logic        w_win_shift;

  // Next-state decode and combinational handshake/shift outputs.
  always_comb begin
    w_state_nxt = r_state;
    pix_ready   = 1'b0;
    lb_shift    = 1'b0;
    w_accept    = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        pix_ready = 1'b1;
        w_accept  = pix_valid;
        lb_shift  = pix_valid;
        if (pix_valid && (r_pix_cnt == (TOTAL_PIX - 22'd1))) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        lb_shift = 1'b1;
        if (r_shift_cnt == FLUSH_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_frame_start = (r_state == ST_IDLE) && start;
  // A shift moves a real pixel into the center once the window is primed.
  assign w_win_shift   = lb_shift && (r_shift_cnt >= WIN_START);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-frame accept/shift counters and next center-coordinate tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt   <= 22'd0;
      r_shift_cnt <= 22'd0;
      r_cen_col   <= 11'd0;
      r_cen_row   <= 11'd0;
    end else if (w_frame_start) begin
      r_pix_cnt   <= 22'd0;
      r_shift_cnt <= 22'd0;
      r_cen_col   <= 11'd0;
      r_cen_row   <= 11'd0;
    end else begin
      if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 22'd1;
      end
      if (lb_shift) begin
        r_shift_cnt <= r_shift_cnt + 22'd1;
      end
      if (w_win_shift) begin
        if (r_cen_col == (PIC_WIDTH - 11'd1)) begin
          r_cen_col <= 11'd0;
          r_cen_row <= r_cen_row + 11'd1;
        end else begin
          r_cen_col <= r_cen_col + 11'd1;
        end
      end
    end
  end

  // Registered window outputs; coordinates and flags hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      out_col   <= 11'd0;
      out_row   <= 11'd0;
      border    <= 4'b0000;
    end else begin
      win_valid <= w_win_shift;
      if (w_win_shift) begin
        out_col <= r_cen_col;
        out_row <= r_cen_row;
        border  <= {(r_cen_row == 11'd0),
                    (r_cen_row == (PIC_HEIGHT - 11'd1)),
                    (r_cen_col == 11'd0),
                    (r_cen_col == (PIC_WIDTH - 11'd1))};
      end
    end
  end

endmodule
